aes_key_expand: RTL and testbench

AES_KEY_EXPAND -- requirements
Module: aes_key_expand

---
 rtl/aes_pkg.sv | 35 +++
 rtl/aes_sbox.sv | 60 ++++++
 rtl/aes_key_expand.sv | 154 +++++++++++++++
 tb/tb_aes_key_expand.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg -- shared constants and types for the AES key schedule and datapath.
//   NR          : number of AES-128 rounds (10)
//   ks_state_e  : key-expansion FSM states (IDLE / EMIT)
//   rcon()      : round-constant table, indexed by round number 1..10
// -----------------------------------------------------------------------------
package aes_pkg;

  localparam logic [3:0] NR = 4'd10;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } ks_state_e;

  // Round constant for round 1..10; any other index yields zero.
  function automatic logic [7:0] rcon(input logic [3:0] round);
    logic [7:0] rc_s;
    case (round)
      4'd1:    rc_s = 8'h01;
      4'd2:    rc_s = 8'h02;
      4'd3:    rc_s = 8'h04;
      4'd4:    rc_s = 8'h08;
      4'd5:    rc_s = 8'h10;
      4'd6:    rc_s = 8'h20;
      4'd7:    rc_s = 8'h40;
      4'd8:    rc_s = 8'h80;
      4'd9:    rc_s = 8'h1b;
      4'd10:   rc_s = 8'h36;
      default: rc_s = 8'h00;
    endcase
    return rc_s;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// -----------------------------------------------------------------------------
// aes_sbox -- combinational AES forward S-box.
//   sbox_in  [7:0] : input byte
//   sbox_out [7:0] : substituted byte
// The byte is inverted in GF(2^8) (x^254, which maps 0 to 0) and then passed
// through the AES affine transform, so no 256-entry table is stored.
// -----------------------------------------------------------------------------
module aes_sbox (
  input  logic [7:0] sbox_in,
  output logic [7:0] sbox_out
);

  // Multiply by x modulo the AES polynomial x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc_s;
    logic [7:0] sh_s;
    acc_s = 8'h00;
    sh_s  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        acc_s = acc_s ^ sh_s;
      end else begin
        acc_s = acc_s;
      end
      sh_s = xtime(sh_s);
    end
    return acc_s;
  endfunction

  // a^254 = a^(2+4+8+16+32+64+128): accumulate successive squares.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] pw_s;
    logic [7:0] acc_s;
    pw_s  = a;
    acc_s = 8'h01;
    for (int i = 1; i < 8; i++) begin
      pw_s  = gf_mul(pw_s, pw_s);
      acc_s = gf_mul(acc_s, pw_s);
    end
    return acc_s;
  endfunction

  logic [7:0] inv_s;

  // Inversion followed by the affine transform b ^ rotl1..4(b) ^ 0x63.
  always_comb begin
    inv_s    = gf_inv(sbox_in);
    sbox_out = inv_s
             ^ {inv_s[6:0], inv_s[7]}
             ^ {inv_s[5:0], inv_s[7:6]}
             ^ {inv_s[4:0], inv_s[7:5]}
             ^ {inv_s[3:0], inv_s[7:4]}
             ^ 8'h63;
  end

endmodule

// File: rtl/aes_key_expand.sv
// -----------------------------------------------------------------------------
// aes_key_expand -- AES-128 key schedule, one round key per cycle.
//   clk, rst        : clock, synchronous active-high reset
//   start, key_in   : load a cipher key (accepted while ready=1)
//   ready           : idle, can accept start
//   round_key,rk_idx: current round key (w0 in [127:96]) and its round 0..10
//   rk_valid/rk_ready: valid/ready handshake towards the encrypt stage
//   done            : one-cycle pulse after round key 10 is accepted
//   rd_idx, rd_key  : optional key-store read port
// Build option: define AES_KEY_STORE_EN to keep all 11 round keys in a store
// readable through rd_idx/rd_key; otherwise rd_key is tied to zero.
// -----------------------------------------------------------------------------
module aes_key_expand
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         ready,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] round_key,
  output logic [3:0]   rk_idx,
  output logic         done,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key
);

  ks_state_e    state_r;
  logic [127:0] round_key_r;
  logic [3:0]   rk_idx_r;
  logic         ready_r;
  logic         rk_valid_r;
  logic         done_r;

  logic [31:0]  rot_s;
  logic [31:0]  sub_s;
  logic [31:0]  t_s;
  logic [31:0]  n0_s, n1_s, n2_s, n3_s;
  logic [3:0]   next_idx_s;
  logic [127:0] next_key_s;
  logic         handshake_s;

  assign handshake_s = rk_valid_r & rk_ready;
  assign rot_s       = {round_key_r[23:0], round_key_r[31:24]};

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_subword
      aes_sbox u_sbox (
        .sbox_in  (rot_s[8*g +: 8]),
        .sbox_out (sub_s[8*g +: 8])
      );
    end
  endgenerate

  // Next round key from the current one; rcon uses the round being produced.
  always_comb begin
    next_idx_s = rk_idx_r + 4'd1;
    t_s        = sub_s ^ {rcon(next_idx_s), 24'h000000};
    n0_s       = round_key_r[127:96] ^ t_s;
    n1_s       = round_key_r[95:64]  ^ n0_s;
    n2_s       = round_key_r[63:32]  ^ n1_s;
    n3_s       = round_key_r[31:0]   ^ n2_s;
    next_key_s = {n0_s, n1_s, n2_s, n3_s};
  end

  // Control FSM and registered outputs; start is only looked at in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      round_key_r <= 128'h0;
      rk_idx_r    <= 4'd0;
      ready_r     <= 1'b1;
      rk_valid_r  <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r     <= ST_EMIT;
            round_key_r <= key_in;
            rk_idx_r    <= 4'd0;
            ready_r     <= 1'b0;
            rk_valid_r  <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_EMIT: begin
          if (rk_ready) begin
            if (rk_idx_r == NR) begin
              state_r    <= ST_IDLE;
              ready_r    <= 1'b1;
              rk_valid_r <= 1'b0;
              done_r     <= 1'b1;
            end else begin
              round_key_r <= next_key_s;
              rk_idx_r    <= next_idx_s;
            end
          end else begin
            state_r <= ST_EMIT;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          ready_r    <= 1'b1;
          rk_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign ready     = ready_r;
  assign rk_valid  = rk_valid_r;
  assign round_key = round_key_r;
  assign rk_idx    = rk_idx_r;
  assign done      = done_r;

`ifdef AES_KEY_STORE_EN
  logic [127:0] store_r [0:10];

  // Capture each round key as the downstream stage accepts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 11; i++) begin
        store_r[i] <= 128'h0;
      end
    end else if (handshake_s) begin
      store_r[rk_idx_r] <= round_key_r;
    end else begin
      store_r[0] <= store_r[0];
    end
  end

  // Combinational read; indices past round 10 read as zero.
  always_comb begin
    if (rd_idx <= NR) begin
      rd_key = store_r[rd_idx];
    end else begin
      rd_key = 128'h0;
    end
  end
`else
  logic rd_idx_unused_s;
  logic hs_unused_s;
  assign rd_idx_unused_s = ^rd_idx;
  assign hs_unused_s     = handshake_s;
  assign rd_key          = 128'h0;
`endif

endmodule

// File: tb/tb_aes_key_expand.sv
// -----------------------------------------------------------------------------
// tb_aes_key_expand -- self-checking bench for aes_key_expand.
// A reference key schedule (S-box generated from the GF(2^8) generator walk,
// word-array FIPS-197 expansion) plus a transaction-level model of the
// handshake is compared with the DUT on every falling edge.
// -----------------------------------------------------------------------------
module tb_aes_key_expand;

  logic         clk = 1'b0;
  logic         rst, start, rk_ready;
  logic [127:0] key_in;
  logic [3:0]   rd_idx;
  logic         ready, rk_valid, done;
  logic [127:0] round_key, rd_key;
  logic [3:0]   rk_idx;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [127:0] K_FIPS  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K_FIPS1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K_FIPS10= 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K_ZERO1 = 128'h62636363626363636263636362636363;
  localparam logic [127:0] K_ZERO10= 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K3 = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] K4 = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

  always #5 clk = ~clk;

  aes_key_expand dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key_in    (key_in),
    .ready     (ready),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .round_key (round_key),
    .rk_idx    (rk_idx),
    .done      (done),
    .rd_idx    (rd_idx),
    .rd_key    (rd_key)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // ---------------- reference key schedule ----------------
  logic [7:0]   sbox_tbl [0:255];
  logic [127:0] m_keys  [0:10];
  logic [127:0] m_store [0:10];

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sbox_tbl[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_tbl[0] = 8'h63;
  endtask

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_tbl[t[31:24]], sbox_tbl[t[23:16]], sbox_tbl[t[15:8]], sbox_tbl[t[7:0]]};
        t = t ^ {rc, 24'h000000};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) m_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- transaction model + per-cycle compare ----------------
  logic         m_busy, m_done;
  logic [3:0]   m_idx;
  logic [127:0] m_round_key;
  logic [127:0] exp_rd;
  bit           model_live = 1'b0;

  always @(negedge clk) begin
    if (model_live) begin
      chk1("ready", ready, !m_busy);
      chk1("rk_valid", rk_valid, m_busy);
      chk1("done", done, m_done);
      chk("rk_idx", {124'h0, rk_idx}, {124'h0, m_idx});
      chk("round_key", round_key, m_round_key);
`ifdef AES_KEY_STORE_EN
      exp_rd = (rd_idx <= 4'd10) ? m_store[rd_idx] : 128'h0;
`else
      exp_rd = 128'h0;
`endif
      chk("rd_key", rd_key, exp_rd);
    end
    // Advance the model to what the next rising edge must produce.
    if (rst) begin
      m_busy = 1'b0; m_done = 1'b0; m_idx = 4'd0; m_round_key = 128'h0;
      for (int i = 0; i < 11; i++) m_store[i] = 128'h0;
    end else begin
      m_done = 1'b0;
      if (!m_busy) begin
        if (start) begin
          expand(key_in);
          m_busy = 1'b1; m_idx = 4'd0; m_round_key = m_keys[0];
        end
      end else if (rk_ready) begin
        m_store[m_idx] = m_keys[m_idx];
        if (m_idx == 4'd10) begin
          m_busy = 1'b0; m_done = 1'b1;
        end else begin
          m_idx = m_idx + 4'd1;
          m_round_key = m_keys[m_idx];
        end
      end
    end
    model_live = 1'b1;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idx(input logic [3:0] target, input string name);
    int k;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (rk_valid === 1'b1 && rk_idx === target) break;
    end
    if (k == 100) begin
      n_checks++; n_errors++;
      $display("FAIL %s: timeout waiting for rk_idx %0d", name, target);
    end
  endtask

  task automatic wait_done(input string name);
    int k;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (done === 1'b1) break;
    end
    if (k == 300) begin
      n_checks++; n_errors++;
      $display("FAIL %s: timeout waiting for done", name);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int hs;
    logic [127:0] exp_r10;
    rst = 1'b1; start = 1'b0; rk_ready = 1'b1; key_in = 128'h0; rd_idx = 4'd0;

    // Pin the reference model to published vectors.
    build_sbox();
    expand(K_FIPS);
    chk("model_fips_rk1", m_keys[1], K_FIPS1);
    chk("model_fips_rk10", m_keys[10], K_FIPS10);
    expand(128'h0);
    chk("model_zero_rk1", m_keys[1], K_ZERO1);
    chk("model_zero_rk10", m_keys[10], K_ZERO10);

    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk1("reset_ready", ready, 1'b1);
    chk1("reset_valid", rk_valid, 1'b0);
    chk("reset_key", round_key, 128'h0);
    tick();

    // FIPS-197 key, no back-pressure: latency and done timing.
    key_in = K_FIPS; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (k == 1) chk("fips_rk0", round_key, K_FIPS);
      if (k == 2) chk("fips_rk1", round_key, K_FIPS1);
      if (k == 11) chk("fips_rk10", round_key, K_FIPS10);
      chk1("done_timing", done, k == 12);
    end
    tick();

`ifdef AES_KEY_STORE_EN
    exp_r10 = K_FIPS10;
`else
    exp_r10 = 128'h0;
`endif
    rd_idx = 4'd10;
    @(negedge clk);
    chk("rd_idx10", rd_key, exp_r10);
    tick();
    rd_idx = 4'd15;
    @(negedge clk);
    chk("rd_idx15", rd_key, 128'h0);
    tick();

    // All-zero key.
    key_in = 128'h0; start = 1'b1;
    tick();
    start = 1'b0;
    wait_idx(4'd1, "zero_wait1");
    chk("zero_rk1", round_key, K_ZERO1);
    wait_idx(4'd10, "zero_wait10");
    chk("zero_rk10", round_key, K_ZERO10);
    wait_done("zero_done");
    tick();

    // Random back-pressure on the FIPS key; model checks hold/order.
    key_in = K_FIPS; start = 1'b1; rk_ready = 1'b0;
    tick();
    start = 1'b0;
    hs = 0;
    for (int k = 0; k < 400; k++) begin
      rk_ready = 1'($urandom_range(0, 1));
      rd_idx   = 4'($urandom_range(0, 15));
      @(negedge clk);
      if (rk_valid && rk_ready) hs++;
      if (done) break;
      tick();
    end
    chk("bp_handshakes", 128'(hs), 128'd11);
    chk1("bp_done_seen", done, 1'b1);
    tick();
    rk_ready = 1'b1;

    // start held through EMIT; key_in changes mid-run must be ignored.
    key_in = K2; start = 1'b1;
    tick();
    key_in = K3;
    wait_done("hold_done1");
    tick();
    @(negedge clk);
    chk("hold_second_key", round_key, K3);
    tick();
    start = 1'b0;
    wait_done("hold_done2");
    tick();

    // Reset in the middle of an expansion, then a fresh run.
    key_in = K4; start = 1'b1;
    tick();
    start = 1'b0;
    wait_idx(4'd5, "abort_wait5");
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; rd_idx = 4'd3;
    @(negedge clk);
    chk("abort_key", round_key, 128'h0);
    chk("abort_rd", rd_key, 128'h0);
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      chk1("abort_no_done", done, 1'b0);
    end
    tick();
    key_in = K3; start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("restart_rk0", round_key, K3);
    wait_done("restart_done");
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
